// File: rtl/m31_pkg.sv
// Shared M31 field types and constants for the Poseidon2 datapath.
// TAG_W exists only when M31_SBOX_TAG_EN is defined.
package m31_pkg;

    typedef logic [30:0] m31_t;

    localparam m31_t P_M31 = 31'h7FFF_FFFF;
    localparam int SBOX_LAT = 3;

`ifdef M31_SBOX_TAG_EN
    localparam int TAG_W = 8;
`endif

endpackage

// File: rtl/m31_mul.sv
// Combinational a*b mod (2^31-1) with a canonical result.
// Shared by the S-box and the linear-layer stages.
module m31_mul
    import m31_pkg::*;
(
    input  m31_t a,
    input  m31_t b,
    output m31_t y
);

    logic [61:0] p;
    logic [31:0] s;
    m31_t        t;

    // 2^31 == 1 mod P, so the high half folds onto the low half
    always_comb begin
        p = {31'd0, a} * {31'd0, b};
        s = {1'b0, p[30:0]} + {1'b0, p[61:31]};
        t = s[30:0] + {30'd0, s[31]};
        y = (t == P_M31) ? '0 : t;
    end

endmodule

// File: rtl/m31_sbox_pow5.sv
// Poseidon2 S-box stage: y = x^5 mod (2^31-1), 3-stage valid/ready pipeline.
// Optional beat tag (tag_i/tag_o) enabled by defining M31_SBOX_TAG_EN.
module m31_sbox_pow5
    import m31_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  m31_t             x_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
`ifdef M31_SBOX_TAG_EN
    input  logic [TAG_W-1:0] tag_i,
    output logic [TAG_W-1:0] tag_o,
`endif
    output m31_t             y_o
);

    logic advance;
    logic v1, v2, v3;

    m31_t s1_x, s1_x2;
    m31_t s2_x, s2_x4;
    m31_t s3_y;

    m31_t sq_x, sq_x2, mul_y;

    m31_mul u_mul_sq (
        .a (x_i),
        .b (x_i),
        .y (sq_x)
    );

    m31_mul u_mul_x4 (
        .a (s1_x2),
        .b (s1_x2),
        .y (sq_x2)
    );

    m31_mul u_mul_y (
        .a (s2_x4),
        .b (s2_x),
        .y (mul_y)
    );

    // Whole pipe moves in lockstep; bubbles are kept, never squeezed out
    assign advance     = ~v3 | out_ready_i;
    assign in_ready_o  = advance;
    assign out_valid_o = v3;
    assign y_o         = s3_y;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1    <= 1'b0;
            v2    <= 1'b0;
            v3    <= 1'b0;
            s1_x  <= '0;
            s1_x2 <= '0;
            s2_x  <= '0;
            s2_x4 <= '0;
            s3_y  <= '0;
        end else if (advance) begin
            v1 <= in_valid_i;
            v2 <= v1;
            v3 <= v2;
            if (in_valid_i) begin
                s1_x  <= x_i;
                s1_x2 <= sq_x;
            end
            if (v1) begin
                s2_x  <= s1_x;
                s2_x4 <= sq_x2;
            end
            if (v2) begin
                s3_y <= mul_y;
            end
        end
    end

`ifdef M31_SBOX_TAG_EN
    logic [TAG_W-1:0] s1_tag, s2_tag, s3_tag;

    assign tag_o = s3_tag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_tag <= '0;
            s2_tag <= '0;
            s3_tag <= '0;
        end else if (advance) begin
            if (in_valid_i) s1_tag <= tag_i;
            if (v1)         s2_tag <= s1_tag;
            if (v2)         s3_tag <= s2_tag;
        end
    end
`endif

endmodule

// File: doc/m31_sbox_pow5.md
Name: m31_sbox_pow5

Overview:
- Poseidon2 S-box stage: computes y = x^5 mod P (P = 2^31-1) for one M31 lane per beat.
- Sits directly downstream of the round-constant adder (m31_add) and consumes its canonical sum.
- 3-stage pipeline with valid/ready handshake and full backpressure; one result per cycle sustained.

Parameters:
- None. Lane width fixed by m31_t (31 bits).

Ports:
- clk  input  1  clock, all state rising-edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid_i  input  1  x_i valid.
- in_ready_o  output  1  stage accepts x_i this cycle.
- x_i  input  31 (m31_t)  operand; canonical [0, P-1]; value P treated as 0.
- out_valid_o  output  1  y_o valid.
- out_ready_i  input  1  downstream accepts y_o.
- y_o  output  31 (m31_t)  x^5 mod P, always canonical.

Behaviour:
- Reset (async assert, sync deassert by integrator): all stage valid bits v1..v3 = 0; out_valid_o = 0; y_o = 0; data registers cleared to 0.
- Pipeline:
  - S1 registers x and x2 = x*x mod P.
  - S2 registers x and x4 = x2*x2 mod P.
  - S3 registers y = x4*x mod P.
- Latency: 3 cycles from an accepted input (in_valid_i & in_ready_o) to out_valid_o, with no stalls.
- Handshake and stall control:
  - advance = ~v3 | out_ready_i. All stages shift together when advance = 1; all hold when advance = 0.
  - in_ready_o = advance. This is a combinational path from out_ready_i; accepted and documented.
  - On advance: v1 <= in_valid_i, v2 <= v1, v3 <= v2. Data registers load only when the feeding valid is 1; otherwise they hold.
  - Bubbles propagate as invalid slots and are not compressed.
- Output stability: while out_valid_o = 1 and out_ready_i = 0, y_o and out_valid_o hold stable.
- Simultaneous events: pop at S3 and push at S1 in the same cycle gives full throughput.
- Pipeline full (v1..v3 = 1) with out_ready_i = 0: in_ready_o = 0 and the input is not consumed.
- Modular multiply rule:
  - 62-bit product p.
  - s = p[30:0] + p[61:31] (32 bits).
  - t = s[30:0] + s[31].
  - If t == P then result 0, else t.
- Inputs equal to P yield 0, identical to input 0.
- Reset mid-operation clears all in-flight beats; no output is produced for them.

Optional Feature:
- Macro M31_SBOX_TAG_EN.
- Defined:
  - Adds ports tag_i (input, TAG_W = 8 bits) and tag_o (output, 8 bits).
  - The tag travels with its beat through S1..S3 under identical stall rules.
  - tag_o resets to 0 and is valid when out_valid_o = 1.
  - Used to carry the lane/round index for the state-permutation controller.
- Undefined: no tag ports or registers; behaviour otherwise identical.

Decomposition:
- m31_pkg holds m31_t, P_M31, and the new constant SBOX_LAT = 3. TAG_W = 8 is a localparam under the macro.
- One sub-module: m31_mul, combinational a*b mod P, canonical output. It is instantiated three times and is reused by the linear-layer stages.

Test Plan:
- Reset/idle: assert rst for 3 cycles while in_valid_i = 1 -> out_valid_o = 0, y_o = 0 throughout; after release, first output appears exactly 3 cycles after the first accepted beat.
- Known values, streaming with out_ready_i = 1 and back-to-back inputs 0, 1, 2, 3, P-1, 2^30 -> outputs 0, 1, 32, 243, P-1 (= -1), 67108864 (2^26), one per cycle starting cycle 3.
- Non-canonical input x = P -> y = 0; random canonical x against a 64-bit reference model, 10k beats.
- Backpressure:
  - Fill pipeline, hold out_ready_i = 0 for 5 cycles -> in_ready_o = 0, y_o stable, no beat lost or duplicated.
  - Release -> in-order drain plus simultaneous acceptance.
- Random in_valid_i / out_ready_i (50% each): scoreboard checks order and values; throughput equals 1 beat/cycle when both are held high.
- Mid-flight reset: 2 beats in flight, pulse rst asynchronously (not clock-aligned) -> out_valid_o drops immediately, neither beat emerges. With M31_SBOX_TAG_EN, tags 0xA5 and 0x3C match their beats in the stall tests.
